// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for regfile_arbiter: op encodings, issue-stage control
// bundle and the op decoder used when a grant is registered.
package regfile_arbiter_pkg;

  localparam int unsigned REQ_N = 2;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_INC = 2'b01,
    OP_DEC = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  // ld marks ops whose data word is forwarded to rf_result
  typedef struct packed {
    logic we;
    logic inc;
    logic dec;
    logic ld;
  } rf_ctrl_t;

  function automatic rf_ctrl_t decode_op(input logic [1:0] op);
    rf_ctrl_t c;
    c = '0;
    case (op_e'(op))
      OP_WR:   begin c.we = 1'b1; c.ld  = 1'b1; end
      OP_INC:  begin c.we = 1'b1; c.inc = 1'b1; end
      OP_DEC:  begin c.we = 1'b1; c.dec = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_arbiter_arb_pick2.sv
// Two-way winner selection: a lone eligible requester wins outright, a tie
// is broken by ptr (0 favours requester 0, 1 favours requester 1).
module arb_pick2
  import regfile_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] eligible,
  input  logic             ptr,
  output logic [REQ_N-1:0] grant
);

  always_comb begin
    grant = eligible;
    if (eligible == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester register-file write arbiter with a one-cycle issue stage.
// Define REGFILE_ARBITER_RR_EN for round-robin ties; default is fixed priority.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter  int unsigned SIZE  = 1,
  parameter  int unsigned COUNT = 1,
  // a single-register file still needs a 1-bit address bus
  localparam int unsigned AW    = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            req0,
  input  logic            req1,
  input  logic [1:0]      op0,
  input  logic [1:0]      op1,
  input  logic [AW-1:0]   dst0,
  input  logic [AW-1:0]   dst1,
  input  logic [SIZE-1:0] dat0,
  input  logic [SIZE-1:0] dat1,
  output logic            ack0,
  output logic            ack1,
  output logic            rf_we,
  output logic            rf_inc,
  output logic            rf_dec,
  output logic [AW-1:0]   rf_dst,
  output logic [SIZE-1:0] rf_result
);

  logic [REQ_N-1:0] eligible;
  logic [REQ_N-1:0] grant;
  logic             ptr;
  logic [1:0]       sel_op;
  logic [AW-1:0]    sel_dst;
  logic [SIZE-1:0]  sel_dat;
  rf_ctrl_t         sel_ctrl;

  // a requester whose ack is showing is already done with this transaction
  assign eligible = hold ? '0 : {req1 & ~ack1, req0 & ~ack0};

  arb_pick2 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant)
  );

`ifdef REGFILE_ARBITER_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= grant[0];
    end
  end
`else
  assign ptr = 1'b0;
`endif

  always_comb begin
    sel_op  = op0;
    sel_dst = dst0;
    sel_dat = dat0;
    if (grant[1]) begin
      sel_op  = op1;
      sel_dst = dst1;
      sel_dat = dat1;
    end
  end

  assign sel_ctrl = decode_op(sel_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rf_we     <= 1'b0;
      rf_inc    <= 1'b0;
      rf_dec    <= 1'b0;
      rf_dst    <= '0;
      rf_result <= '0;
    end else begin
      ack0   <= grant[0];
      ack1   <= grant[1];
      rf_we  <= (|grant) & sel_ctrl.we;
      rf_inc <= (|grant) & sel_ctrl.inc;
      rf_dec <= (|grant) & sel_ctrl.dec;
      if (|grant) begin
        rf_dst <= sel_dst;
        if (sel_ctrl.ld) begin
          rf_result <= sel_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: directed stimulus pushes expected
// issue records, a negedge monitor pops and compares them.
module tb_regfile_arbiter;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned COUNT = 8;
  localparam int unsigned AW    = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            hold = 1'b0;
  logic            req0 = 1'b0;
  logic            req1 = 1'b0;
  logic [1:0]      op0 = '0;
  logic [1:0]      op1 = '0;
  logic [AW-1:0]   dst0 = '0;
  logic [AW-1:0]   dst1 = '0;
  logic [SIZE-1:0] dat0 = '0;
  logic [SIZE-1:0] dat1 = '0;
  logic            ack0, ack1, rf_we, rf_inc, rf_dec;
  logic [AW-1:0]   rf_dst;
  logic [SIZE-1:0] rf_result;

  typedef struct {
    int              cyc;
    logic            who;
    logic            we;
    logic            inc;
    logic            dec;
    logic [AW-1:0]   dst;
    logic [SIZE-1:0] res;
    logic            chk_res;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic first;

  regfile_arbiter #(.SIZE(SIZE), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .dst0(dst0), .dst1(dst1), .dat0(dat0), .dat1(dat1),
    .ack0(ack0), .ack1(ack1), .rf_we(rf_we), .rf_inc(rf_inc), .rf_dec(rf_dec),
    .rf_dst(rf_dst), .rf_result(rf_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic who, input logic we, input logic inc,
                      input logic dec, input logic [AW-1:0] dst, input logic [SIZE-1:0] res,
                      input logic chk_res);
    exp_t x;
    x.cyc = c; x.who = who; x.we = we; x.inc = inc; x.dec = dec;
    x.dst = dst; x.res = res; x.chk_res = chk_res;
    sb.push_back(x);
  endtask

  // monitor
  always @(negedge clk) begin
    check("inc_dec_excl", 32'(rf_inc & rf_dec), 32'd0);
    if (ack0 | ack1) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({ack1, ack0}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_who", 32'({ack1, ack0}), e.who ? 32'd2 : 32'd1);
        check("rf_we", 32'(rf_we), 32'(e.we));
        check("rf_inc", 32'(rf_inc), 32'(e.inc));
        check("rf_dec", 32'(rf_dec), 32'(e.dec));
        check("rf_dst", 32'(rf_dst), 32'(e.dst));
        if (e.chk_res) check("rf_result", 32'(rf_result), 32'(e.res));
      end
    end else begin
      check("idle_strobes", 32'({rf_we, rf_inc, rf_dec}), 32'd0);
      if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("missing_ack", 32'({ack1, ack0}), e.who ? 32'd2 : 32'd1);
      end
    end
  end

  initial begin
    // reset state
    tick(2);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_strobes", 32'({rf_we, rf_inc, rf_dec}), 32'd0);
    check("rst_dst", 32'(rf_dst), 32'd0);
    check("rst_result", 32'(rf_result), 32'd0);

    // single write, granted on the first edge after reset release
    req0 = 1'b1; op0 = 2'b00; dst0 = 3'd3; dat0 = 8'h5A; rst = 1'b0;
    push(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 8'h5A, 1'b1);
    tick(1); req0 = 1'b0;
    tick(1);
    check("idle_hold_dst", 32'(rf_dst), 32'd3);
    check("idle_hold_result", 32'(rf_result), 32'h5A);

    // nop from requester 1
    req1 = 1'b1; op1 = 2'b11; dst1 = 3'd7; dat1 = 8'hFF;
    push(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0);
    tick(1); req1 = 1'b0;
    tick(1);

    // contention, same dst: inc from 0, dec from 1
    req0 = 1'b1; op0 = 2'b01; dst0 = 3'd1;
    req1 = 1'b1; op1 = 2'b10; dst1 = 3'd1;
    push(cyc + 1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
    push(cyc + 2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0);
    tick(1); req0 = 1'b0;
    tick(1); req1 = 1'b0;
    tick(1);

    // lone grant to 0, then a tie resolved by the priority scheme
    req0 = 1'b1; op0 = 2'b00; dst0 = 3'd2; dat0 = 8'h21;
    push(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h21, 1'b1);
    tick(1); req0 = 1'b0;
    tick(1);
`ifdef REGFILE_ARBITER_RR_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    req0 = 1'b1; op0 = 2'b00; dst0 = 3'd4; dat0 = 8'h44;
    req1 = 1'b1; op1 = 2'b00; dst1 = 3'd5; dat1 = 8'h55;
    push(cyc + 1, first, 1'b1, 1'b0, 1'b0, first ? 3'd5 : 3'd4, first ? 8'h55 : 8'h44, 1'b1);
    push(cyc + 2, !first, 1'b1, 1'b0, 1'b0, first ? 3'd4 : 3'd5, first ? 8'h44 : 8'h55, 1'b1);
    tick(1);
    if (first) req1 = 1'b0; else req0 = 1'b0;
    tick(1); req0 = 1'b0; req1 = 1'b0;
    tick(1);

    // sustained dual requests alternate every cycle
    req0 = 1'b1; op0 = 2'b00; dst0 = 3'd6; dat0 = 8'h60;
    req1 = 1'b1; op1 = 2'b00; dst1 = 3'd7; dat1 = 8'h70;
    for (int k = 0; k < 6; k++) begin
      logic w;
      w = first ^ k[0];
      push(cyc + 1 + k, w, 1'b1, 1'b0, 1'b0, w ? 3'd7 : 3'd6, w ? 8'h70 : 8'h60, 1'b1);
    end
    tick(6); req0 = 1'b0; req1 = 1'b0;
    tick(2);

    // hold: registered issue survives, pending req1 waits for hold release
    req0 = 1'b1; op0 = 2'b00; dst0 = 3'd2; dat0 = 8'h11;
    push(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h11, 1'b1);
    tick(1);
    hold = 1'b1; req0 = 1'b0;
    req1 = 1'b1; op1 = 2'b00; dst1 = 3'd5; dat1 = 8'h33;
    push(cyc + 5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h33, 1'b1);
    tick(4); hold = 1'b0;
    tick(1); req1 = 1'b0;
    tick(1);

    // reset during an issue: the issue is dropped, request re-presented
    req0 = 1'b1; op0 = 2'b00; dst0 = 3'd6; dat0 = 8'h99;
    tick(1); rst = 1'b1;
    #1;
    check("midrst_acks", 32'({ack1, ack0}), 32'd0);
    check("midrst_strobes", 32'({rf_we, rf_inc, rf_dec}), 32'd0);
    check("midrst_dst", 32'(rf_dst), 32'd0);
    check("midrst_result", 32'(rf_result), 32'd0);
    tick(1); rst = 1'b0;
    push(cyc + 1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 8'h99, 1'b1);
    tick(1); req0 = 1'b0;
    tick(3);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
